score_display: RTL and testbench

//  Downstream consumer of collision and game-state signals. Keeps a 4-digit BCD

---
 rtl/score_display_pkg.sv | 41 ++++
 rtl/ssd_scan_mux.sv | 72 +++++++
 rtl/score_display.sv | 96 +++++++++
 tb/tb_score_display.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the score display: seven-segment cathode patterns,
// digit counts, and a nibble-to-segment decoder.
// Cathode bit order is {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low. Dp is always off.
package score_display_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam int DIGITS_PER_GROUP = 4;

    localparam logic [7:0] SSD_0     = 8'b0000_0011;
    localparam logic [7:0] SSD_1     = 8'b1001_1111;
    localparam logic [7:0] SSD_2     = 8'b0010_0101;
    localparam logic [7:0] SSD_3     = 8'b0000_1101;
    localparam logic [7:0] SSD_4     = 8'b1001_1001;
    localparam logic [7:0] SSD_5     = 8'b0100_1001;
    localparam logic [7:0] SSD_6     = 8'b0100_0001;
    localparam logic [7:0] SSD_7     = 8'b0001_1111;
    localparam logic [7:0] SSD_8     = 8'b0000_0001;
    localparam logic [7:0] SSD_9     = 8'b0000_1001;
    localparam logic [7:0] SSD_BLANK = 8'b1111_1111;

    // Non-decimal nibbles cannot come from the BCD registers in normal
    // operation; they are shown dark rather than as hex glyphs.
    function automatic logic [7:0] ssd_decode(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'd0:    seg = SSD_0;
            4'd1:    seg = SSD_1;
            4'd2:    seg = SSD_2;
            4'd3:    seg = SSD_3;
            4'd4:    seg = SSD_4;
            4'd5:    seg = SSD_5;
            4'd6:    seg = SSD_6;
            4'd7:    seg = SSD_7;
            4'd8:    seg = SSD_8;
            4'd9:    seg = SSD_9;
            default: seg = SSD_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_mux.sv
// Eight-digit seven-segment scan multiplexer.
// A free-running divider advances a 3-bit scan index each time it wraps.
// Digits 0-3 come from score_bcd, digits 4-7 from high_bcd, with leading-zero
// blanking inside each 4-digit group (the lowest digit of a group is always lit).
// Ports:
//   ClkPort   in   system clock
//   reset     in   asynchronous, active-high
//   score_bcd in   16-bit BCD score, [3:0] = units
//   high_bcd  in   16-bit BCD high score
//   An        out  anodes, active-low, exactly one low
//   Cathodes  out  {Ca..Cg,Dp}, active-low
module ssd_scan_mux
    import score_display_pkg::*;
#(
    parameter int SCAN_BITS = 18
) (
    input  logic                  ClkPort,
    input  logic                  reset,
    input  logic [15:0]           score_bcd,
    input  logic [15:0]           high_bcd,
    output logic [NUM_DIGITS-1:0] An,
    output logic [7:0]            Cathodes
);

    logic [SCAN_BITS-1:0]  div;
    logic [2:0]            scan_idx;
    logic [15:0]           group;
    logic [1:0]            pos;
    logic [3:0]            nibble;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            cath_next;

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            div      <= '0;
            scan_idx <= 3'd0;
        end else begin
            div <= div + 1'b1;
            if (&div)
                scan_idx <= scan_idx + 3'd1;
        end
    end

    // Upper half of the index selects the high-score group (4 digits per group).
    always_comb begin
        group     = scan_idx[2] ? high_bcd : score_bcd;
        pos       = scan_idx[1:0];
        nibble    = group[{pos, 2'b00} +: 4];
        case (pos)
            2'd1:    blank = (group[15:4]  == 12'd0);
            2'd2:    blank = (group[15:8]  == 8'd0);
            2'd3:    blank = (group[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        an_next   = ~(NUM_DIGITS'(1) << scan_idx);
        cath_next = blank ? SSD_BLANK : ssd_decode(nibble);
    end

    // Anode and cathode share one register stage so a digit change never
    // shows the previous digit's segments on the new anode.
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            An       <= 8'b1111_1110;
            Cathodes <= SSD_0;
        end else begin
            An       <= an_next;
            Cathodes <= cath_next;
        end
    end

endmodule

// File: rtl/score_display.sv
// Score keeper and display driver.
// Counts hits into a 4-digit BCD score (saturating at 9999), latches a session
// high score on entry to win/lose, and drives the 8-digit seven-segment display
// through ssd_scan_mux (score on digits 0-3, high score on digits 4-7).
// Ports:
//   ClkPort      in   100 MHz system clock
//   reset        in   asynchronous, active-high
//   game_start   in   level; holds score at 0
//   game_playing in   level; hits counted only while high
//   game_win     in   level
//   game_lose    in   level
//   hit_pulse    in   one-cycle pulse per enemy destroyed
//   score_bcd    out  current score, BCD, [3:0] = units
//   high_bcd     out  high score, BCD
//   An           out  anodes, active-low
//   Cathodes     out  {Ca..Cg,Dp}, active-low
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_BITS   = 18,
    parameter int POINTS      = 1,
    parameter int POINT_DIGIT = 1
) (
    input  logic                  ClkPort,
    input  logic                  reset,
    input  logic                  game_start,
    input  logic                  game_playing,
    input  logic                  game_win,
    input  logic                  game_lose,
    input  logic                  hit_pulse,
    output logic [15:0]           score_bcd,
    output logic [15:0]           high_bcd,
    output logic [NUM_DIGITS-1:0] An,
    output logic [7:0]            Cathodes
);

    localparam logic [4:0] ADD_VAL = 5'(POINTS);

    logic [15:0] score_inc;
    logic [4:0]  sum;
    logic        carry;
    logic        wl_q;
    logic        wl_rise;

    // Decimal add with the carry rippling through all four digits in one
    // cycle; a carry out of the top digit pins the score at 9999.
    always_comb begin
        score_inc = score_bcd;
        carry     = 1'b0;
        sum       = 5'd0;
        for (int d = 0; d < DIGITS_PER_GROUP; d++) begin
            sum = {1'b0, score_bcd[d*4 +: 4]} + ((d == POINT_DIGIT) ? ADD_VAL : 5'd0)
                  + {4'd0, carry};
            if (sum > 5'd9) begin
                sum   = sum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            score_inc[d*4 +: 4] = sum[3:0];
        end
        if (carry)
            score_inc = 16'h9999;
    end

    assign wl_rise = (game_win | game_lose) & ~wl_q;

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            score_bcd <= 16'h0000;
            high_bcd  <= 16'h0000;
            wl_q      <= 1'b0;
        end else begin
            wl_q <= game_win | game_lose;
            if (game_start)
                score_bcd <= 16'h0000;
            else if (game_playing && hit_pulse)
                score_bcd <= score_inc;
            // Valid BCD orders the same as its binary encoding.
            if (wl_rise && (score_bcd > high_bcd))
                high_bcd <= score_bcd;
        end
    end

    ssd_scan_mux #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .ClkPort   (ClkPort),
        .reset     (reset),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .An        (An),
        .Cathodes  (Cathodes)
    );

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

    localparam int SCAN_BITS = 4;
    localparam int HOLD      = 1 << SCAN_BITS;
    localparam int HIT_VALUE = 10;

    logic        ClkPort = 1'b0;
    logic        reset;
    logic        game_start, game_playing, game_win, game_lose, hit_pulse;
    logic [15:0] score_bcd, high_bcd;
    logic [7:0]  An, Cathodes;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    int m_score, m_high;
    bit m_wl;

    score_display #(.SCAN_BITS(SCAN_BITS)) dut (
        .ClkPort      (ClkPort),
        .reset        (reset),
        .game_start   (game_start),
        .game_playing (game_playing),
        .game_win     (game_win),
        .game_lose    (game_lose),
        .hit_pulse    (hit_pulse),
        .score_bcd    (score_bcd),
        .high_bcd     (high_bcd),
        .An           (An),
        .Cathodes     (Cathodes)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] seg_of(input int v);
        case (v)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_cath(input int i);
        int val, d, p;
        val = (i < 4) ? m_score : m_high;
        d   = i % 4;
        p   = 10 ** d;
        if (d != 0 && val < p) return 8'hFF;
        return seg_of((val / p) % 10);
    endfunction

    function automatic int idx_of(input logic [7:0] an);
        int r = -1;
        for (int j = 0; j < 8; j++) if (an[j] == 1'b0) r = j;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge.
    always @(posedge ClkPort) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (score_bcd !== mon_e[31:16]) begin
                fails++;
                $display("FAIL score: got %h expected %h", score_bcd, mon_e[31:16]);
            end
            tests++;
            if (high_bcd !== mon_e[15:0]) begin
                fails++;
                $display("FAIL high: got %h expected %h", high_bcd, mon_e[15:0]);
            end
        end
    end

    task automatic cycle(input logic st, input logic pl, input logic w, input logic l,
                         input logic h);
        bit rise;
        @(negedge ClkPort);
        game_start   = st;
        game_playing = pl;
        game_win     = w;
        game_lose    = l;
        hit_pulse    = h;
        rise = (w | l) && !m_wl;
        m_wl = w | l;
        if (rise && m_score > m_high) m_high = m_score;
        if (st) m_score = 0;
        else if (pl && h) m_score = (m_score + HIT_VALUE > 9999) ? 9999 : m_score + HIT_VALUE;
        exp_q.push_back({to_bcd(m_score), to_bcd(m_high)});
    endtask

    task automatic hits(input int n);
        for (int k = 0; k < n; k++) cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
    endtask

    task automatic check_digit(input int i);
        logic [7:0] ean;
        int cnt;
        ean = ~(8'd1 << i);
        cnt = 0;
        @(posedge ClkPort); #1;
        while (An !== ean && cnt < 300) begin
            @(posedge ClkPort); #1;
            cnt++;
        end
        tests++;
        if (cnt >= 300) begin
            fails++;
            $display("FAIL digit%0d_wait: An=%h never reached %h", i, An, ean);
        end else begin
            chk($sformatf("digit%0d_cath", i), {8'h00, Cathodes}, {8'h00, exp_cath(i)});
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge ClkPort); #3;
        reset = 1'b1;
        #1;
        chk({tag, "_an"},    {8'h00, An},       16'h00FE);
        chk({tag, "_cath"},  {8'h00, Cathodes}, 16'h0003);
        chk({tag, "_score"}, score_bcd,         16'h0000);
        chk({tag, "_high"},  high_bcd,          16'h0000);
        m_score = 0; m_high = 0; m_wl = 0;
        @(negedge ClkPort);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] prev;
        int n, cur;
        reset = 1'b1;
        game_start = 0; game_playing = 0; game_win = 0; game_lose = 0; hit_pulse = 0;
        m_score = 0; m_high = 0; m_wl = 0;
        repeat (3) @(negedge ClkPort);
        chk("rst_an",    {8'h00, An},       16'h00FE);
        chk("rst_cath",  {8'h00, Cathodes}, 16'h0003);
        chk("rst_score", score_bcd,         16'h0000);
        chk("rst_high",  high_bcd,          16'h0000);
        reset = 1'b0;

        // three hits, two of them back to back
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        @(posedge ClkPort); #2;
        chk("score_0030", score_bcd, 16'h0030);
        for (int i = 0; i < 8; i++) check_digit(i);

        // reset in the middle of a scan and a game
        async_reset_check("midreset");

        // start overrides hit; hits ignored while not playing
        cycle(0, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        @(posedge ClkPort); #2;
        chk("not_playing", score_bcd, 16'h0010);

        // high score on lose, kept when a lower score wins
        cycle(1, 0, 0, 0, 0);
        hits(12);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        @(posedge ClkPort); #2;
        chk("high_0120", high_bcd, 16'h0120);
        cycle(1, 0, 0, 0, 0);
        hits(5);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        @(posedge ClkPort); #2;
        chk("high_kept", high_bcd, 16'h0120);
        for (int i = 0; i < 8; i++) check_digit(i);

        // decimal carry and saturation
        cycle(1, 0, 0, 0, 0);
        hits(99);
        hits(1);
        @(posedge ClkPort); #2;
        chk("carry_1000", score_bcd, 16'h1000);
        hits(899);
        hits(2);
        @(posedge ClkPort); #2;
        chk("saturate", score_bcd, 16'h9999);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) check_digit(i);

        async_reset_check("midgame");

        // randomized play
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) check_digit(i);

        // scan timing: every digit held HOLD cycles, walking one position up
        n = 0;
        prev = An;
        while (An === prev && n < 100) begin
            @(posedge ClkPort); #1;
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL scan_sync: An stuck at %h", An);
        end
        for (int k = 0; k < 9; k++) begin
            prev = An;
            cur  = idx_of(prev);
            chk("scan_onehot", 16'($countones(~prev)), 16'd1);
            n = 1;
            @(posedge ClkPort); #1;
            while (An === prev && n < 100) begin
                n++;
                @(posedge ClkPort); #1;
            end
            chk("scan_hold", 16'(n), 16'(HOLD));
            chk("scan_next", {8'h00, An}, {8'h00, ~(8'd1 << ((cur + 1) % 8))});
        end

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge ClkPort); #2;
            n++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
